// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and state type for the binary-to-BCD converter
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Evaluated at elaboration only, to check that DIGITS covers the input range
    function automatic longint unsigned pow10(input int n);
        longint unsigned acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adj
);

    assign adj = (digit >= ADJ_THRESH) ? (digit + ADJ_ADD) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary to packed BCD converter (optional BCD_SIGNED_INPUT_EN)
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 26,
    parameter int DIGITS   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [IN_WIDTH-1:0]           bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [DIGITS*BCD_DIGIT_W-1:0] bcd_out,
    output logic                          neg
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);
    localparam longint unsigned MAX_BIN = (64'd1 << IN_WIDTH) - 64'd1;

    if (pow10(DIGITS) <= MAX_BIN) begin : g_range_check
        $error("bin_to_bcd_seq: DIGITS too small for IN_WIDTH");
    end

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [IN_WIDTH-1:0] shift_bin;
    logic [BCD_W-1:0]    bcd_work;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_next;
    logic [IN_WIDTH-1:0] bin_next;
    logic [IN_WIDTH-1:0] load_val;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (bcd_work[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adj   (bcd_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign {bcd_next, bin_next} = {bcd_adj, shift_bin} << 1;

`ifdef BCD_SIGNED_INPUT_EN
    logic neg_pend;

    // Magnitude of the most negative value is 2^(IN_WIDTH-1), which still fits unsigned
    assign load_val = bin_in[IN_WIDTH-1]
                    ? ((~bin_in) + {{(IN_WIDTH-1){1'b0}}, 1'b1})
                    : bin_in;
`else
    assign load_val = bin_in;
    assign neg      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_bin <= '0;
            bcd_work  <= '0;
            bcd_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef BCD_SIGNED_INPUT_EN
            neg_pend  <= 1'b0;
            neg       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        shift_bin <= load_val;
                        bcd_work  <= '0;
                        cnt       <= '0;
                        state     <= CONV;
`ifdef BCD_SIGNED_INPUT_EN
                        neg_pend  <= bin_in[IN_WIDTH-1];
`endif
                    end
                end
                CONV: begin
                    shift_bin <= bin_next;
                    bcd_work  <= bcd_next;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        // Final shift lands straight in the display register
                        bcd_out <= bcd_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
`ifdef BCD_SIGNED_INPUT_EN
                        neg     <= neg_pend;
`endif
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
